// File: rtl/player_motion_if.sv
// player_motion_if: button/vsync inputs and committed position outputs of the player motion sequencer
interface player_motion_if;
  logic       vsync;
  logic       enable;
  logic       left;
  logic       right;
  logic       up;
  logic       flip_vert;
  logic       home;
  logic [9:0] x;
  logic [9:0] y;
  logic       step_done;
  logic       busy;
  modport master (
    output vsync, enable, left, right, up, flip_vert, home,
    input  x, y, step_done, busy
  );
  modport slave (
    input  vsync, enable, left, right, up, flip_vert, home,
    output x, y, step_done, busy
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: frame-synchronous sprite position sequencer with clamped, atomic x/y commit
module player_motion_ctrl #(
  parameter int X_RESET         = 310,
  parameter int Y_RESET         = 230,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 620,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 460,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_STEP = 2
) (
  input logic            clk,
  input logic            rst,
  player_motion_if.slave pm
);
  localparam logic [10:0] XR  = 11'(X_RESET);
  localparam logic [10:0] YR  = 11'(Y_RESET);
  localparam logic [10:0] XMN = 11'(X_MIN);
  localparam logic [10:0] XMX = 11'(X_MAX);
  localparam logic [10:0] YMN = 11'(Y_MIN);
  localparam logic [10:0] YMX = 11'(Y_MAX);
  localparam logic [10:0] ST  = 11'(STEP);
  localparam logic [7:0]  FPS_M1 = 8'(FRAMES_PER_STEP - 1);
  typedef enum logic [2:0] {IDLE, WAIT_FRAME, SAMPLE, APPLY, COMMIT} state_t;
  state_t      state, state_nxt;
  logic [7:0]  frame_cnt, frame_cnt_nxt;
  logic        vs_d, frame_tick;
  logic        l_left, l_right, l_up, l_flip, l_home;
  logic [10:0] xsum, ysum;
  logic [9:0]  x_calc, y_calc, nx, ny, x_q, y_q;
  assign frame_tick   = vs_d & ~pm.vsync;
  assign pm.x         = x_q;
  assign pm.y         = y_q;
  assign pm.step_done = state == COMMIT;
  assign pm.busy      = state == SAMPLE || state == APPLY || state == COMMIT;
  // sequencer state and frame divider registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end
  // next state: enable is only honoured before a sequence starts; ticks are ignored once busy
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    case (state)
      IDLE: begin
        state_nxt     = pm.enable ? WAIT_FRAME : IDLE;
        frame_cnt_nxt = pm.enable ? '0 : frame_cnt;
      end
      WAIT_FRAME: begin
        if (!pm.enable) begin
          state_nxt     = IDLE;
          frame_cnt_nxt = '0;
        end else if (frame_tick) begin
          state_nxt     = frame_cnt == FPS_M1 ? SAMPLE : WAIT_FRAME;
          frame_cnt_nxt = frame_cnt == FPS_M1 ? '0 : frame_cnt + 8'd1;
        end
      end
      SAMPLE:  state_nxt = APPLY;
      APPLY:   state_nxt = COMMIT;
      COMMIT:  state_nxt = WAIT_FRAME;
      default: state_nxt = IDLE;
    endcase
  end
  // clamped next position; sums carry an extra bit so the upper clamp never sees a wrapped value
  always_comb begin
    xsum   = {1'b0, x_q} + ST;
    ysum   = {1'b0, y_q} + ST;
    x_calc = l_home ? XR[9:0] :
             (l_left & ~l_right) ? ({1'b0, x_q} < XMN + ST ? XMN[9:0] : x_q - ST[9:0]) :
             (l_right & ~l_left) ? (xsum > XMX ? XMX[9:0] : xsum[9:0]) : x_q;
    y_calc = l_home ? YR[9:0] : ~l_up ? y_q :
             l_flip ? (ysum > YMX ? YMX[9:0] : ysum[9:0]) :
             ({1'b0, y_q} < YMN + ST ? YMN[9:0] : y_q - ST[9:0]);
  end
  // vsync edge flop, input latch, working position and atomic commit of x/y
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_d    <= 1'b1;
      l_left  <= 1'b0;
      l_right <= 1'b0;
      l_up    <= 1'b0;
      l_flip  <= 1'b0;
      l_home  <= 1'b0;
      nx      <= XR[9:0];
      ny      <= YR[9:0];
      x_q     <= XR[9:0];
      y_q     <= YR[9:0];
    end else begin
      vs_d <= pm.vsync;
      if (state == SAMPLE) begin
        l_left  <= pm.left;
        l_right <= pm.right;
        l_up    <= pm.up;
        l_flip  <= pm.flip_vert;
        l_home  <= pm.home;
      end
      if (state == APPLY) begin
        nx <= x_calc;
        ny <= y_calc;
      end
      if (state == COMMIT) begin
        x_q <= nx;
        y_q <= ny;
      end
    end
  end
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed and random frame sequences checked against a clamp-arithmetic model
module tb_player_motion_ctrl;
  localparam int XR = 310, YR = 230, XMN = 0, XMX = 620, YMN = 0, YMX = 460, ST = 3, FPS = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  player_motion_if pm();
  player_motion_ctrl #(
    .X_RESET(XR), .Y_RESET(YR), .X_MIN(XMN), .X_MAX(XMX), .Y_MIN(YMN), .Y_MAX(YMX),
    .STEP(ST), .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pm(pm)
  );
  int n_cmp  = 0;
  int n_fail = 0;
  int mx = XR, my = YR, fc = 0;
  bit men = 1'b0;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int clampi(input int v, input int lo, input int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
  task automatic set_en(input bit v);
    @(negedge clk);
    pm.enable = v;
    men = v;
    fc = 0;
    repeat (3) @(negedge clk);
  endtask
  // one vsync falling edge; l/r/u/f/h are the values present in the SAMPLE cycle
  task automatic frame(input bit l, input bit r, input bit u, input bit f, input bit h,
                       input bit glitch = 1'b0, input bit drop_en = 1'b0, input bit rst_mid = 1'b0);
    bit step;
    int ex, ey;
    @(negedge clk);
    pm.left = glitch ? 1'b1 : l;
    pm.right = r;
    pm.up = u;
    pm.flip_vert = f;
    pm.home = h;
    pm.vsync = 1'b0;
    step = 1'b0;
    if (men) begin
      fc++;
      if (fc == FPS) begin
        step = 1'b1;
        fc = 0;
      end
    end
    ex = h ? XR : clampi(mx + (int'(r) - int'(l)) * ST, XMN, XMX);
    ey = h ? YR : !u ? my : clampi(my + (f ? ST : -ST), YMN, YMX);
    @(negedge clk);
    chk("busy_sample", 16'(pm.busy), 16'(step));
    if (glitch) pm.left = l;
    @(negedge clk);
    if (glitch) pm.left = 1'b1;
    pm.vsync = 1'b1;
    if (drop_en) begin
      pm.enable = 1'b0;
      men = 1'b0;
      fc = 0;
    end
    if (rst_mid) begin
      rst = 1'b0;
      #1;
      chk("rst_x", 16'(pm.x), 16'(XR));
      chk("rst_y", 16'(pm.y), 16'(YR));
      chk("rst_busy", 16'(pm.busy), 16'd0);
      chk("rst_done", 16'(pm.step_done), 16'd0);
      mx = XR;
      my = YR;
      fc = 0;
      @(negedge clk);
      rst = 1'b1;
    end else begin
      @(negedge clk);
      chk("done_commit", 16'(pm.step_done), 16'(step));
      chk("x_before", 16'(pm.x), 16'(mx));
      chk("y_before", 16'(pm.y), 16'(my));
      @(negedge clk);
      if (step) begin
        mx = ex;
        my = ey;
      end
      chk("x_after", 16'(pm.x), 16'(mx));
      chk("y_after", 16'(pm.y), 16'(my));
      chk("done_after", 16'(pm.step_done), 16'd0);
      chk("busy_after", 16'(pm.busy), 16'd0);
    end
    pm.left = l;
    repeat ($urandom_range(2, 5)) @(negedge clk);
  endtask
  initial begin
    pm.vsync = 1'b1;
    pm.enable = 1'b0;
    pm.left = 1'b0;
    pm.right = 1'b0;
    pm.up = 1'b0;
    pm.flip_vert = 1'b0;
    pm.home = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_x", 16'(pm.x), 16'(XR));
    chk("reset_y", 16'(pm.y), 16'(YR));
    chk("reset_busy", 16'(pm.busy), 16'd0);
    chk("reset_done", 16'(pm.step_done), 16'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    set_en(1'b1);
    repeat (4) frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("x_after_4_ticks", 16'(pm.x), 16'(XR + 2 * ST));
    repeat (220) frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("x_clamp_max", 16'(pm.x), 16'(XMX));
    repeat (420) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("x_clamp_min", 16'(pm.x), 16'(XMN));
    repeat (4) frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (160) frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("y_clamp_min", 16'(pm.y), 16'(YMN));
    repeat (320) frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("y_clamp_max", 16'(pm.y), 16'(YMX));
    repeat (2) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("home_x", 16'(pm.x), 16'(XR));
    chk("home_y", 16'(pm.y), 16'(YR));
    repeat (4) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("glitch_x", 16'(pm.x), 16'(XR));
    while (fc != FPS - 1) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_en(1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_en(1'b1);
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    while (fc != FPS - 1) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_en(1'b1);
    while (fc != FPS - 1) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) frame(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (300) begin
      if ($urandom_range(0, 19) == 0) set_en(~men);
      frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
